draw_port_arbiter: RTL

- Shares the single VGA pixel-write port among several rectangle-draw requesters: alien clear/kill, alien row shift, shot, player.
- Round-robin grant; the granted rectangle is latched and rasterised one pixel per clock.
- A one-cycle done pulse goes back to the requester; it drives the alien controller's clearedShift and cleared1..cleared5 inputs.
- Sits between the game-object controllers and the VGA adapter.

---
 rtl/draw_port_arbiter_pkg.sv | 29 ++
 rtl/draw_port_arbiter_rr_priority_picker.sv | 39 +++
 rtl/draw_port_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/draw_port_arbiter_pkg.sv
// Shared constants, state encoding and pixel helpers for the draw-port arbiter.
//   SCREEN_W/SCREEN_H : visible raster size; pixels outside it are clipped
//   COLOUR_W          : colour bits per pixel
//   X_W/Y_W           : pixel coordinate widths
package draw_port_arbiter_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index width for an N-entry requester vector (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when the pixel lies inside the visible screen area.
  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
  endfunction

endpackage

// File: rtl/draw_port_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: scans req starting at rr_ptr, wrapping
// modulo N_REQ, and reports the first set bit.
//   req          : request vector
//   rr_ptr       : index searched first
//   valid_c      : some request is set
//   win_idx_c    : winning index
//   win_onehot_c : winning index as a one-hot vector
module rr_priority_picker
  import draw_port_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid_c,
  output logic [IDX_W-1:0] win_idx_c,
  output logic [N_REQ-1:0] win_onehot_c
);

  // Candidate k is (rr_ptr + k) mod N_REQ; the first hit wins.
  always_comb begin
    int unsigned cand;
    cand         = 0;
    valid_c      = 1'b0;
    win_idx_c    = '0;
    win_onehot_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!valid_c && req[IDX_W'(cand)]) begin
        valid_c                        = 1'b1;
        win_idx_c                      = IDX_W'(cand);
        win_onehot_c[IDX_W'(cand)]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_port_arbiter.sv
// Shares the single VGA pixel-write port among N_REQ rectangle-draw
// requesters. A round-robin winner's rectangle is latched and rasterised
// x-major, one pixel per clock, then a one-cycle done pulse is returned.
//   clk, reset       : clock, asynchronous active-low reset
//   req              : per-requester level request, held until done
//   rect_x0/y0/x1/y1 : per-requester inclusive rectangle corners (slice i)
//   rect_colour      : per-requester fill colour
//   grant            : one-hot owner of the port from accept through DONE
//   done             : one-cycle completion pulse to the owner
//   vga_x/y/colour   : current pixel
//   vga_plot         : pixel write enable (off-screen pixels clipped)
//   busy             : arbiter not in IDLE
module draw_port_arbiter
  import draw_port_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [X_W*N_REQ-1:0]      rect_x0,
  input  logic [Y_W*N_REQ-1:0]      rect_y0,
  input  logic [X_W*N_REQ-1:0]      rect_x1,
  input  logic [Y_W*N_REQ-1:0]      rect_y1,
  input  logic [COLOUR_W*N_REQ-1:0] rect_colour,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic [X_W-1:0]            vga_x,
  output logic [Y_W-1:0]            vga_y,
  output logic [COLOUR_W-1:0]       vga_colour,
  output logic                      vga_plot,
  output logic                      busy
);

  localparam int unsigned IDX_W = idx_width(N_REQ);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d;
  logic                busy_q, busy_d;
  logic [X_W-1:0]      x0_q, x0_d;
  logic [X_W-1:0]      x1_q, x1_d;
  logic [Y_W-1:0]      y1_q, y1_d;

  logic                pick_valid_c;
  logic [IDX_W-1:0]    pick_idx_c;
  logic [N_REQ-1:0]    pick_onehot_c;

  logic [X_W-1:0]      sel_x0, sel_x1;
  logic [Y_W-1:0]      sel_y0, sel_y1;
  logic [COLOUR_W-1:0] sel_colour;

  rr_priority_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req          (req),
    .rr_ptr       (rr_ptr_q),
    .valid_c      (pick_valid_c),
    .win_idx_c    (pick_idx_c),
    .win_onehot_c (pick_onehot_c)
  );

  // Select the winning requester's rectangle slice.
  always_comb begin
    sel_x0     = '0;
    sel_y0     = '0;
    sel_x1     = '0;
    sel_y1     = '0;
    sel_colour = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx_c == IDX_W'(i)) begin
        sel_x0     = rect_x0[i*X_W +: X_W];
        sel_y0     = rect_y0[i*Y_W +: Y_W];
        sel_x1     = rect_x1[i*X_W +: X_W];
        sel_y1     = rect_y1[i*Y_W +: Y_W];
        sel_colour = rect_colour[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    grant_d  = grant_q;
    done_d   = '0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          win_d    = pick_idx_c;
          grant_d  = pick_onehot_c;
          x0_d     = sel_x0;
          x1_d     = sel_x1;
          y1_d     = sel_y1;
          x_d      = sel_x0;
          y_d      = sel_y0;
          colour_d = sel_colour;
          // Empty rectangles skip straight to completion.
          if ((sel_x1 < sel_x0) || (sel_y1 < sel_y0)) begin
            state_d = DONE;
            done_d  = pick_onehot_c;
          end else begin
            state_d = DRAW;
          end
        end
      end

      DRAW: begin
        // Compare with the latched ends before stepping so 255/127 never wrap.
        if (x_q == x1_q) begin
          if (y_q == y1_q) begin
            state_d = DONE;
            done_d  = grant_q;
          end else begin
            x_d = x0_q;
            y_d = y_q + Y_W'(1);
          end
        end else begin
          x_d = x_q + X_W'(1);
        end
      end

      DONE: begin
        state_d  = IDLE;
        grant_d  = '0;
        rr_ptr_d = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    // The plot flag belongs to the pixel presented in the next cycle.
    plot_d = (state_d == DRAW) && on_screen(x_d, y_d);
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      x0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = colour_q;
  assign vga_plot   = plot_q;
  assign busy       = busy_q;

endmodule
